// File: rtl/rsa_two_power_mod_arbiter.sv
// rtl/rsa_two_power_mod_arbiter.sv - round-robin arbiter sharing one 2^p mod N engine between two requesters
module rsa_two_power_mod_arbiter #(
  parameter int MOD_WIDTH   = 256,
  parameter int POWER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [MOD_WIDTH-1:0]   req0_modulus,
  input  logic [POWER_WIDTH-1:0] req0_power,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [MOD_WIDTH-1:0]   req1_modulus,
  input  logic [POWER_WIDTH-1:0] req1_power,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [MOD_WIDTH-1:0]   rsp0_out,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [MOD_WIDTH-1:0]   rsp1_out,
  output logic                   eng_i_valid,
  input  logic                   eng_i_ready,
  output logic [MOD_WIDTH-1:0]   eng_i_modulus,
  output logic [POWER_WIDTH-1:0] eng_i_power,
  input  logic                   eng_o_valid,
  output logic                   eng_o_ready,
  input  logic [MOD_WIDTH-1:0]   eng_o_out,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   tag_q, tag_d;
  logic [MOD_WIDTH-1:0]   mod_q, mod_d;
  logic [MOD_WIDTH-1:0]   res_q, res_d;
  logic [POWER_WIDTH-1:0] pow_q, pow_d;

  logic                   grant;
  logic                   accept;
  logic                   rsp_take;
  logic [MOD_WIDTH-1:0]   acc_mod;
  logic [POWER_WIDTH-1:0] acc_pow;

  // Priority pointer only breaks ties; a lone requester always wins.
  assign grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign acc_mod    = grant ? req1_modulus : req0_modulus;
  assign acc_pow    = grant ? req1_power : req0_power;
  assign rsp_take   = tag_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    mod_d   = mod_q;
    pow_d   = pow_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mod_d = acc_mod;
          pow_d = acc_pow;
          tag_d = grant;
          // 2^0 is answered locally as 1, without reduction, so the engine never sees p==0.
          if (acc_pow == '0) begin
            res_d   = MOD_WIDTH'(1);
            state_d = RESPOND;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (eng_i_ready) state_d = WAIT;
      end
      WAIT: begin
        if (eng_o_valid) begin
          res_d   = eng_o_out;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_take) begin
          ptr_d   = ~tag_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      tag_q   <= 1'b0;
      mod_q   <= '0;
      pow_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      mod_q   <= mod_d;
      pow_q   <= pow_d;
      res_q   <= res_d;
    end
  end

  assign eng_i_valid   = (state_q == ISSUE);
  assign eng_i_modulus = mod_q;
  assign eng_i_power   = pow_q;
  assign eng_o_ready   = (state_q == WAIT);
  assign rsp0_valid    = (state_q == RESPOND) && !tag_q;
  assign rsp1_valid    = (state_q == RESPOND) && tag_q;
  assign rsp0_out      = res_q;
  assign rsp1_out      = res_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_two_power_mod_arbiter.sv
// tb/tb_rsa_two_power_mod_arbiter.sv - scoreboard bench with behavioural engine and modular-exponent reference
module tb_rsa_two_power_mod_arbiter;
  localparam int MW = 256;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MW-1:0] req0_modulus, req1_modulus;
  logic [PW-1:0] req0_power, req1_power;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [MW-1:0] rsp0_out, rsp1_out;
  logic          eng_i_valid, eng_i_ready, eng_o_valid, eng_o_ready;
  logic [MW-1:0] eng_i_modulus, eng_o_out;
  logic [PW-1:0] eng_i_power;
  logic          busy;

  rsa_two_power_mod_arbiter #(.MOD_WIDTH(MW), .POWER_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_modulus(req0_modulus), .req0_power(req0_power),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_modulus(req1_modulus), .req1_power(req1_power),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
    .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready), .eng_i_modulus(eng_i_modulus), .eng_i_power(eng_i_power),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_out(eng_o_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int outstanding = 0;
  int pri = 0;
  int eng_stall = 0;
  int eng_lat_fixed = -1;
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;

  logic [MW-1:0] exp0_q[$];
  logic [MW-1:0] exp1_q[$];
  logic [MW-1:0] eng_n_q[$];
  logic [PW-1:0] eng_p_q[$];
  int            grant_log[$];

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Square-and-multiply reference; p==0 yields 1 regardless of N.
  function automatic logic [MW-1:0] ref_pow2(input logic [MW-1:0] n, input logic [PW-1:0] p);
    logic [2*MW-1:0] r, b, nn;
    if (p == 0) return MW'(1);
    nn = {{MW{1'b0}}, n};
    r  = 1 % nn;
    b  = 2 % nn;
    for (int i = 0; i < PW; i++) begin
      if (p[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[MW-1:0];
  endfunction

  // Engine result by repeated modular doubling.
  function automatic logic [MW-1:0] eng_model(input logic [MW-1:0] n, input logic [PW-1:0] p);
    logic [MW:0] x;
    x = (n == 1) ? '0 : (MW+1)'(1);
    for (int i = 0; i < int'(p); i++) begin
      x = x << 1;
      if (x >= {1'b0, n}) x = x - {1'b0, n};
    end
    return x[MW-1:0];
  endfunction

  initial begin : engine
    int            phase, cnt, stall;
    logic          s_rst, s_in, s_out, s_v;
    logic [MW-1:0] s_n, res;
    logic [PW-1:0] s_p;
    phase = 0; cnt = 0; stall = 0; res = '0;
    eng_i_ready = 1'b0; eng_o_valid = 1'b0; eng_o_out = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_in = eng_i_valid && eng_i_ready; s_out = eng_o_valid && eng_o_ready;
      s_v = eng_i_valid; s_n = eng_i_modulus; s_p = eng_i_power;
      @(posedge clk); #1;
      if (s_rst) begin
        phase = 0; stall = 0; eng_i_ready = 1'b0; eng_o_valid = 1'b0;
      end else begin
        case (phase)
          0: begin
            if (s_in) begin
              eng_i_ready = 1'b0;
              res = eng_model(s_n, s_p);
              cnt = (eng_lat_fixed >= 0) ? eng_lat_fixed : int'($urandom_range(0, 3));
              phase = 1;
            end else if (s_v) begin
              if (stall < eng_stall) begin stall++; eng_i_ready = 1'b0; end
              else eng_i_ready = 1'b1;
            end
          end
          1: begin
            if (cnt == 0) begin eng_o_valid = 1'b1; eng_o_out = res; phase = 2; end
            else cnt--;
          end
          default: begin
            if (s_out) begin eng_o_valid = 1'b0; phase = 0; stall = 0; end
          end
        endcase
      end
    end
  end

  initial begin : consumers
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp0_ready = !hold0 && ($urandom_range(0, 3) != 0);
      rsp1_ready = !hold1 && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    logic          p_eiv, p_eir, p_r0v, p_r0r, p_r1v, p_r1r;
    logic [MW-1:0] p_ein, p_r0o, p_r1o;
    logic [PW-1:0] p_eip;
    logic [MW-1:0] e;
    p_eiv = 0; p_eir = 0; p_r0v = 0; p_r0r = 0; p_r1v = 0; p_r1r = 0;
    p_ein = '0; p_r0o = '0; p_r1o = '0; p_eip = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp0_q.delete(); exp1_q.delete(); eng_n_q.delete(); eng_p_q.delete();
        outstanding = 0; pri = 0;
        p_eiv = 0; p_r0v = 0; p_r1v = 0;
      end else begin
        if (req0_ready && req1_ready) chk("two_ready", 1, 0);
        if (req0_ready || req1_ready) begin
          chk("one_in_flight", outstanding, 0);
          if (req0_valid && req1_valid) chk("rr_grant", req1_ready, pri);
          grant_log.push_back(req1_ready ? 1 : 0);
          outstanding++;
        end
        if (eng_i_valid) begin
          if (p_eiv && !p_eir) begin
            chk("eng_mod_stable", eng_i_modulus, p_ein);
            chk("eng_pow_stable", eng_i_power, p_eip);
          end
          if (eng_n_q.size() == 0) chk("spurious_eng_issue", eng_i_valid, 0);
          else if (eng_i_ready) begin
            chk("eng_modulus", eng_i_modulus, eng_n_q.pop_front());
            chk("eng_power", eng_i_power, eng_p_q.pop_front());
          end
        end
        if (rsp0_valid) begin
          if (p_r0v && !p_r0r) chk("rsp0_stable", rsp0_out, p_r0o);
          if (exp0_q.size() == 0) chk("spurious_rsp0", rsp0_valid, 0);
          else if (rsp0_ready) begin
            e = exp0_q.pop_front();
            chk("rsp0_out", rsp0_out, e);
            outstanding--; pri = 1;
          end
        end
        if (rsp1_valid) begin
          if (p_r1v && !p_r1r) chk("rsp1_stable", rsp1_out, p_r1o);
          if (exp1_q.size() == 0) chk("spurious_rsp1", rsp1_valid, 0);
          else if (rsp1_ready) begin
            e = exp1_q.pop_front();
            chk("rsp1_out", rsp1_out, e);
            outstanding--; pri = 0;
          end
        end
        p_eiv = eng_i_valid; p_eir = eng_i_ready; p_ein = eng_i_modulus; p_eip = eng_i_power;
        p_r0v = rsp0_valid; p_r0r = rsp0_ready; p_r0o = rsp0_out;
        p_r1v = rsp1_valid; p_r1r = rsp1_ready; p_r1o = rsp1_out;
      end
    end
  end

  task automatic set_req(input int k, input logic v, input logic [MW-1:0] n, input logic [PW-1:0] p);
    if (k == 0) begin req0_valid = v; req0_modulus = n; req0_power = p; end
    else begin req1_valid = v; req1_modulus = n; req1_power = p; end
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic drive_req(input int k, input logic [MW-1:0] n, input logic [PW-1:0] p);
    int t = 0;
    bit got = 0;
    set_req(k, 1'b1, n, p);
    while (!got && t < 3000) begin
      @(negedge clk);
      if ((k == 0) ? req0_ready : req1_ready) got = 1;
      else begin @(posedge clk); #1; t++; end
    end
    if (got) begin
      if (k == 0) exp0_q.push_back(ref_pow2(n, p));
      else exp1_q.push_back(ref_pow2(n, p));
      if (p != 0) begin eng_n_q.push_back(n); eng_p_q.push_back(p); end
    end else chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (k == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic rand_req(input int k);
    logic [MW-1:0] n;
    logic [PW-1:0] p;
    for (int w = 0; w < MW / 32; w++) n[w*32 +: 32] = $urandom;
    n = n | MW'(2);
    p = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, 600));
    drive_req(k, n, p);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((busy || outstanding != 0) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) chk("quiet_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eng_i_valid"}, eng_i_valid, 0);
    chk({tag, "_eng_o_ready"}, eng_o_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp_out"}, rsp0_out, 0);
    chk({tag, "_eng_mod"}, eng_i_modulus, 0);
    chk({tag, "_eng_pow"}, eng_i_power, 0);
  endtask

  task automatic check_log(input string name, input int n);
    chk({name, "_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++) chk(name, grant_log[i], i % 2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    bit d0, d1;
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    @(posedge clk); #1; rst = 1'b0;

    drive_req(0, MW'(13), PW'(5));
    @(negedge clk);
    chk("issue_latency", eng_i_valid, 1);
    @(posedge clk); #1;
    wait_quiet();

    do_reset();
    grant_log.delete();
    fork
      drive_req(0, MW'(251), PW'(8));
      drive_req(1, MW'(13), PW'(5));
    join
    wait_quiet();
    check_log("simul_grant", 2);

    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) rand_req(0);
      for (int i = 0; i < 3; i++) rand_req(1);
    join
    wait_quiet();
    check_log("fair_grant", 6);

    drive_req(1, MW'(97), PW'(0));
    @(negedge clk);
    chk("bypass_rsp1_valid", rsp1_valid, 1);
    chk("bypass_eng_idle", eng_i_valid, 0);
    @(posedge clk); #1;
    wait_quiet();
    drive_req(0, MW'(1), PW'(0));
    wait_quiet();

    eng_stall = 5; hold0 = 1'b1; d1 = 0;
    drive_req(0, MW'(13), PW'(5));
    fork
      begin drive_req(1, MW'(251), PW'(8)); d1 = 1; end
    join_none
    for (int t = 0; t < 200 && !rsp0_valid; t++) @(negedge clk);
    chk("bp_rsp0_reached", rsp0_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req1_blocked", req1_ready, 0);
      chk("bp_rsp0_held", rsp0_valid, 1);
    end
    @(posedge clk); #1; hold0 = 1'b0;
    for (int t = 0; t < 500 && !d1; t++) @(posedge clk);
    chk("bp_req1_done", d1, 1);
    #1; wait_quiet();
    eng_stall = 0;

    eng_lat_fixed = 20;
    drive_req(0, MW'(251), PW'(8));
    for (int t = 0; t < 200 && !eng_o_ready; t++) @(negedge clk);
    chk("rst_wait_reached", eng_o_ready, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (30) @(negedge clk);
    eng_lat_fixed = -1;
    @(posedge clk); #1;
    drive_req(1, MW'(13), PW'(5));
    wait_quiet();

    d0 = 0; d1 = 0;
    fork
      begin for (int i = 0; i < 20; i++) begin rand_req(0); repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end end d0 = 1; end
      begin for (int i = 0; i < 20; i++) begin rand_req(1); repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end end d1 = 1; end
    join
    wait_quiet();
    chk("final_exp0_empty", exp0_q.size(), 0);
    chk("final_exp1_empty", exp1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
